// File: rtl/seg7_pkg.sv
// Shared types and constants for the MM:SS seven-segment display stage.
// Holds the converter state enum, digit limits and the active-low segment codes.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVM,
        SPLIT,
        LOAD
    } conv_state_e;

    localparam int          NUM_DIGITS = 4;
    localparam logic [12:0] MAX_COUNT  = 13'd5999;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK = 4'hF;

    function automatic logic [12:0] sat_count(input logic [12:0] v);
        return (v > MAX_COUNT) ? MAX_COUNT : v;
    endfunction

endpackage

// File: rtl/seg7_if.sv
// Bundle between the stopwatch core (master) and the display stage (slave):
// elapsed seconds and adjust controls in, multiplexed segment/anode drive out.
interface seg7_if;
    logic [12:0] seconds;
    logic        adj;
    logic        sel;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    modport master (output seconds, adj, sel, input seg, dp, an);
    modport slave  (input seconds, adj, sel, output seg, dp, an);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 are blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_display.sv
// Seconds-to-MM:SS converter plus 4-digit multiplexed common-anode driver with adjust blink.
// Optional macro SEG7_BLANK_EN blanks a zero minutes-tens digit.
module seg7_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 18,
    parameter int BLINK_DIV = 26
) (
    input  logic   clk,
    input  logic   rst,
    seg7_if.slave  bus
);

    logic [SCAN_DIV-1:0]  presc_q;
    logic [1:0]           idx_q;
    logic [BLINK_DIV-1:0] blink_q;
    logic                 frame_q;
    logic                 step;

    conv_state_e          state_q;
    logic [12:0]          rem_q;
    logic [6:0]           min_q;
    logic [3:0]           mt_q;
    logic [3:0]           st_q;
    logic [3:0]           dig_q [NUM_DIGITS];

    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [3:0]           code_d;

    assign step = &presc_q;

    always_comb begin
        code_d = dig_q[idx_q];
`ifdef SEG7_BLANK_EN
        if (idx_q == 2'd3 && dig_q[3] == 4'd0) begin
            code_d = CODE_BLANK;
        end
`endif
        an_d = ~(4'b0001 << idx_q);
        if (bus.adj && blink_q[BLINK_DIV-1]) begin
            if (bus.sel) begin
                an_d[1:0] = 2'b11;
            end else begin
                an_d[3:2] = 2'b11;
            end
        end
        dp_d = (idx_q != 2'd2);
    end

    seg7_decode u_decode (
        .bcd_i (code_d),
        .seg_o (seg_d)
    );

    // Scan timing and registered display drive; frame_q marks the cycle after idx wraps 3->0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            blink_q <= '0;
            frame_q <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
            blink_q <= blink_q + 1'b1;
            frame_q <= step && (idx_q == 2'd3);
            if (step) begin
                idx_q <= idx_q + 2'd1;
                an_q  <= an_d;
                seg_q <= seg_d;
                dp_q  <= dp_d;
            end
        end
    end

    // Repeated-subtraction converter; digits are written together in LOAD so a frame never tears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            min_q   <= '0;
            mt_q    <= '0;
            st_q    <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_q) begin
                        rem_q   <= sat_count(bus.seconds);
                        min_q   <= '0;
                        mt_q    <= '0;
                        st_q    <= '0;
                        state_q <= DIVM;
                    end
                end
                DIVM: begin
                    if (rem_q >= 13'd60) begin
                        rem_q <= rem_q - 13'd60;
                        min_q <= min_q + 7'd1;
                    end else begin
                        state_q <= SPLIT;
                    end
                end
                SPLIT: begin
                    if (min_q >= 7'd10) begin
                        min_q <= min_q - 7'd10;
                        mt_q  <= mt_q + 4'd1;
                    end
                    if (rem_q >= 13'd10) begin
                        rem_q <= rem_q - 13'd10;
                        st_q  <= st_q + 4'd1;
                    end
                    if (min_q < 7'd10 && rem_q < 13'd10) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    dig_q[0] <= rem_q[3:0];
                    dig_q[1] <= st_q;
                    dig_q[2] <= min_q[3:0];
                    dig_q[3] <= mt_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_display.sv
// Bench for seg7_display: cycle-level display model checked on every falling edge,
// plus directed scenarios pinned by hand-computed segment/anode literals.
module tb_seg7_display;

    localparam int SCAN_DIV  = 8;
    localparam int BLINK_DIV = 12;
    localparam int STEP      = 1 << SCAN_DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;

    seg7_if bus_if ();

    seg7_display #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int         mk;
    int         disp_val;
    int         m_di;
    int         m_ph;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] model_seg(input int v, input int di);
        int mm;
        int ss;
        int d [4];
        mm   = v / 60;
        ss   = v % 60;
        d[0] = ss % 10;
        d[1] = ss / 10;
        d[2] = mm % 10;
        d[3] = mm / 10;
`ifdef SEG7_BLANK_EN
        if (di == 3 && d[3] == 0) return 7'h7F;
`endif
        return seg_tab[d[di]];
    endfunction

    // Display model: counts clocks since reset release and derives every observable from that count
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mk       = 0;
            disp_val = 0;
            exp_an   = 4'b1111;
            exp_seg  = 7'h7F;
            exp_dp   = 1'b1;
        end else begin
            mk = mk + 1;
            if (mk % STEP == 0) begin
                m_di    = (mk / STEP - 1) % 4;
                m_ph    = ((mk - 1) >> (BLINK_DIV - 1)) & 1;
                exp_an  = 4'b1111;
                exp_an[m_di] = 1'b0;
                if (bus_if.adj && m_ph == 1) begin
                    if (bus_if.sel) exp_an[1:0] = 2'b11;
                    else            exp_an[3:2] = 2'b11;
                end
                exp_seg = model_seg(disp_val, m_di);
                exp_dp  = (m_di == 2) ? 1'b0 : 1'b1;
            end
            if (mk > STEP && (mk - 1) % (4 * STEP) == 0) begin
                disp_val = (bus_if.seconds > 13'd5999) ? 5999 : int'(bus_if.seconds);
            end
        end
    end

    always @(negedge clk) begin
        check("an",  {4'h0, bus_if.an},  {4'h0, exp_an});
        check("seg", {1'b0, bus_if.seg}, {1'b0, exp_seg});
        check("dp",  {7'h0, bus_if.dp},  {7'h0, exp_dp});
    end

    task automatic wait_k(input int target);
        do begin
            @(posedge clk);
            #2;
        end while (mk < target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.seconds = 13'd754;
        bus_if.adj     = 1'b0;
        bus_if.sel     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_an",  {4'h0, bus_if.an},  8'h0F);
        check("rst_seg", {1'b0, bus_if.seg}, 8'h7F);
        check("rst_dp",  {7'h0, bus_if.dp},  8'h01);
        rst = 1'b1;

        // Before the first conversion the digit registers read 00:00
        wait_k(256);
        check("first_an",  {4'h0, bus_if.an},  8'h0E);
        check("first_seg", {1'b0, bus_if.seg}, 8'h40);

        // 754 s -> 12:34
        wait_k(2304);
        check("s754_an0",  {4'h0, bus_if.an},  8'h0E);
        check("s754_seg0", {1'b0, bus_if.seg}, 8'h19);
        check("s754_dp0",  {7'h0, bus_if.dp},  8'h01);
        wait_k(2816);
        check("s754_an2",  {4'h0, bus_if.an},  8'h0B);
        check("s754_seg2", {1'b0, bus_if.seg}, 8'h24);
        check("s754_dp2",  {7'h0, bus_if.dp},  8'h00);

        // Saturation: 6039 -> 99:59
        bus_if.seconds = 13'd6039;
        wait_k(3328);
        check("sat_seg0", {1'b0, bus_if.seg}, 8'h10);
        wait_k(4096);
        check("sat_an3",  {4'h0, bus_if.an},  8'h07);
        check("sat_seg3", {1'b0, bus_if.seg}, 8'h10);

        // Input change during DIVM is ignored until the next frame
        bus_if.seconds = 13'd754;
        wait_k(4100);
        bus_if.seconds = 13'd0;
        wait_k(4352);
        check("divm_seg0", {1'b0, bus_if.seg}, 8'h19);
        wait_k(5376);
        check("zero_seg0", {1'b0, bus_if.seg}, 8'h40);
        wait_k(6144);
`ifdef SEG7_BLANK_EN
        check("zero_seg3", {1'b0, bus_if.seg}, 8'h7F);
`else
        check("zero_seg3", {1'b0, bus_if.seg}, 8'h40);
`endif
        check("zero_an3", {4'h0, bus_if.an}, 8'h07);

        // Blink seconds pair
        bus_if.seconds = 13'd754;
        bus_if.adj     = 1'b1;
        bus_if.sel     = 1'b1;
        wait_k(6400);
        check("blk_s_an0",  {4'h0, bus_if.an},  8'h0F);
        check("blk_s_seg0", {1'b0, bus_if.seg}, 8'h19);
        wait_k(6656);
        check("blk_s_an1",  {4'h0, bus_if.an},  8'h0F);
        wait_k(6912);
        check("blk_s_an2",  {4'h0, bus_if.an},  8'h0B);
        check("blk_s_dp2",  {7'h0, bus_if.dp},  8'h00);

        // Blink minutes pair
        wait_k(8192);
        bus_if.sel = 1'b0;
        wait_k(10496);
        check("blk_m_an0", {4'h0, bus_if.an}, 8'h0E);
        wait_k(11008);
        check("blk_m_an2", {4'h0, bus_if.an}, 8'h0F);
        wait_k(11264);
        check("blk_m_an3", {4'h0, bus_if.an}, 8'h0F);
        wait_k(12288);
        bus_if.adj     = 1'b0;
        bus_if.seconds = 13'd5999;

        // Reset in the middle of SPLIT (sample taken at clock 13313)
        wait_k(13417);
        rst = 1'b0;
        #1;
        check("mid_rst_an",  {4'h0, bus_if.an},  8'h0F);
        check("mid_rst_seg", {1'b0, bus_if.seg}, 8'h7F);
        check("mid_rst_dp",  {7'h0, bus_if.dp},  8'h01);
        bus_if.seconds = 13'd754;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        wait_k(256);
        check("post_rst_an0",  {4'h0, bus_if.an},  8'h0E);
        check("post_rst_seg0", {1'b0, bus_if.seg}, 8'h40);
        wait_k(1024);
`ifdef SEG7_BLANK_EN
        check("post_rst_seg3", {1'b0, bus_if.seg}, 8'h7F);
`else
        check("post_rst_seg3", {1'b0, bus_if.seg}, 8'h40);
`endif
        wait_k(1280);
        check("post_rst_754", {1'b0, bus_if.seg}, 8'h19);
        wait_k(2048);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
